// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the rectangle writer and the VGA read side.
// Contents: geometry/width constants, the RGB444 pixel type, the writer FSM
// state type, the latched command payload and a multiplier-free row base helper.
package fb_pkg;

  localparam int unsigned FB_W = 320;
  localparam int unsigned FB_H = 240;
  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 12;
  localparam int unsigned XW   = 9;
  localparam int unsigned YW   = 8;
  localparam int unsigned XEW  = XW + 1;
  localparam int unsigned YEW  = YW + 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } fb_state_e;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    rgb444_t       color;
  } fb_cmd_t;

  // y*320 as (y<<8)+(y<<6)
  function automatic logic [AW-1:0] row_base(input logic [YW-1:0] y);
    return (AW'(y) << 8) + (AW'(y) << 6);
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake plus framebuffer write port of the rectangle writer.
//   master : command source / framebuffer owner (drives cmd_*, stall_i)
//   slave  : the writer engine (drives cmd_ready_o, we_o, addr_o, wdata_o)
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [XW-1:0] cmd_x0_i;
  logic [YW-1:0] cmd_y0_i;
  logic [XW-1:0] cmd_w_i;
  logic [YW-1:0] cmd_h_i;
  logic [DW-1:0] cmd_color_i;
  logic          stall_i;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;

  modport master (
    output cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_w_i, cmd_h_i, cmd_color_i, stall_i,
    input  cmd_ready_o, we_o, addr_o, wdata_o
  );

  modport slave (
    input  cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_w_i, cmd_h_i, cmd_color_i, stall_i,
    output cmd_ready_o, we_o, addr_o, wdata_o
  );

endinterface

// File: rtl/fb_rect_clip.sv
// Combinational clipper: screen-clipped exclusive end column/row, empty flag
// and the address of the first row, from the latched command fields.
//   x0, y0, w, h : latched rectangle
//   x_end_c      : min(x0+w, FB_W), one bit wider than x0 so it cannot wrap
//   y_end_c      : min(y0+h, FB_H), one bit wider than y0
//   empty_c      : nothing to draw
//   row_base0_c  : y0*FB_W
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [XW-1:0]  x0,
  input  logic [YW-1:0]  y0,
  input  logic [XW-1:0]  w,
  input  logic [YW-1:0]  h,
  output logic [XEW-1:0] x_end_c,
  output logic [YEW-1:0] y_end_c,
  output logic           empty_c,
  output logic [AW-1:0]  row_base0_c
);

  logic [XEW-1:0] x_sum;
  logic [YEW-1:0] y_sum;

  always_comb begin
    x_sum       = XEW'(x0) + XEW'(w);
    y_sum       = YEW'(y0) + YEW'(h);
    x_end_c     = (x_sum > XEW'(FB_W)) ? XEW'(FB_W) : x_sum;
    y_end_c     = (y_sum > YEW'(FB_H)) ? YEW'(FB_H) : y_sum;
    empty_c     = (w == '0) || (h == '0) ||
                  (XEW'(x0) >= XEW'(FB_W)) || (YEW'(y0) >= YEW'(FB_H));
    row_base0_c = row_base(y0);
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine for the 320x240 RGB444 framebuffer write port.
// Accepts one command per handshake, clips it to the screen and issues one
// registered pixel write per cycle in row-major order, holding position while
// the write port is lent away.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : command handshake and framebuffer write port (slave side)
//   busy_o   : command in progress (SETUP/RUN/DONE)
//   done_o   : one-cycle completion pulse
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  fb_rect_writer_if.slave        bus,
  output logic                   busy_o,
  output logic                   done_o
);

  fb_state_e      state;
  fb_cmd_t        cmd_q;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;
  logic [AW-1:0]  cur_base;
  logic           last_q;

  logic [XEW-1:0] x_end_c;
  logic [YEW-1:0] y_end_c;
  logic           empty_c;
  logic [AW-1:0]  row_base0_c;

  logic [XW-1:0]  pos_x_c;
  logic [YW-1:0]  pos_y_c;
  logic [AW-1:0]  pos_base_c;
  logic [XW-1:0]  nxt_x_c;
  logic [YW-1:0]  nxt_y_c;
  logic [AW-1:0]  nxt_base_c;
  logic           row_last_c;
  logic           rect_last_c;
  logic           issue_c;

  fb_rect_clip u_clip (
    .x0          (cmd_q.x0),
    .y0          (cmd_q.y0),
    .w           (cmd_q.w),
    .h           (cmd_q.h),
    .x_end_c     (x_end_c),
    .y_end_c     (y_end_c),
    .empty_c     (empty_c),
    .row_base0_c (row_base0_c)
  );

  // Pixel to issue next: the rectangle origin in SETUP, the walker otherwise
  always_comb begin
    pos_x_c    = cur_x;
    pos_y_c    = cur_y;
    pos_base_c = cur_base;
    if (state == SETUP) begin
      pos_x_c    = cmd_q.x0;
      pos_y_c    = cmd_q.y0;
      pos_base_c = row_base0_c;
    end
    row_last_c  = ((XEW'(pos_x_c) + XEW'(1)) == x_end_c);
    rect_last_c = row_last_c && ((YEW'(pos_y_c) + YEW'(1)) == y_end_c);
    nxt_x_c     = row_last_c ? cmd_q.x0 : pos_x_c + XW'(1);
    nxt_y_c     = row_last_c ? pos_y_c + YW'(1) : pos_y_c;
    nxt_base_c  = row_last_c ? pos_base_c + AW'(FB_W) : pos_base_c;
    issue_c     = ((state == SETUP) && !empty_c) || ((state == RUN) && !last_q);
  end

  // FSM with registered outputs; stall_i holds the walker for one write slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cmd_q           <= '0;
      cur_x           <= '0;
      cur_y           <= '0;
      cur_base        <= '0;
      last_q          <= 1'b0;
      bus.cmd_ready_o <= 1'b0;
      bus.we_o        <= 1'b0;
      bus.addr_o      <= '0;
      bus.wdata_o     <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      bus.we_o <= 1'b0;
      done_o   <= 1'b0;

      unique case (state)
        IDLE: begin
          busy_o          <= 1'b0;
          bus.cmd_ready_o <= 1'b1;
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            cmd_q           <= '{x0:    bus.cmd_x0_i,
                                 y0:    bus.cmd_y0_i,
                                 w:     bus.cmd_w_i,
                                 h:     bus.cmd_h_i,
                                 color: rgb444_t'(bus.cmd_color_i)};
            last_q          <= 1'b0;
            bus.cmd_ready_o <= 1'b0;
            busy_o          <= 1'b1;
            state           <= SETUP;
          end
        end
        SETUP: begin
          if (empty_c) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= RUN;
          end
        end
        RUN: begin
          if (last_q) begin
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_o          <= 1'b0;
          bus.cmd_ready_o <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (issue_c) begin
        if (bus.stall_i) begin
          cur_x    <= pos_x_c;
          cur_y    <= pos_y_c;
          cur_base <= pos_base_c;
        end else begin
          bus.we_o    <= 1'b1;
          bus.addr_o  <= pos_base_c + AW'(pos_x_c);
          bus.wdata_o <= cmd_q.color;
          cur_x       <= nxt_x_c;
          cur_y       <= nxt_y_c;
          cur_base    <= nxt_base_c;
          last_q      <= rect_last_c;
        end
      end
    end
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Write-side engine for the 320x240, 12-bit RGB444 framebuffer that the VGA scan-out path reads through its second BRAM port.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Clips each rectangle to the screen and streams one pixel write per cycle, row-major, onto the framebuffer write port (we/addr/wdata).
- Used by the CPU MMIO bridge for clears, fills and single-pixel writes (w=h=1).

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- AW, 17, framebuffer address width.
- DW, 12, pixel width ({r[3:0],g[3:0],b[3:0]}).

Ports:
- clk  in  1  single clock, same domain as the framebuffer write port.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine can accept a command.
- cmd_x0_i  in  9  left column.
- cmd_y0_i  in  8  top row.
- cmd_w_i  in  9  width in pixels.
- cmd_h_i  in  8  height in pixels.
- cmd_color_i  in  DW  fill colour.
- stall_i  in  1  write port lent to another master this cycle.
- we_o  out  1  framebuffer write enable.
- addr_o  out  AW  framebuffer address = y*FB_W + x.
- wdata_o  out  DW  pixel data.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; we_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, cmd_ready_o=0 while held. Reset mid-command aborts it: no further writes, no done_o pulse.
- States: IDLE -> SETUP -> RUN -> DONE -> IDLE.
- IDLE:
  - cmd_ready_o=1, busy_o=0.
  - Handshake on cmd_valid_i & cmd_ready_o at cycle T latches all cmd fields.
- SETUP (cycle T+1):
  - busy_o=1.
  - Clip: x_end = min(x0+w, FB_W), computed 10-bit; y_end = min(y0+h, FB_H), computed 9-bit.
  - Empty if w=0, h=0, x0>=FB_W or y0>=FB_H; empty goes directly to DONE.
  - Row base = y0*320, computed as (y0<<8)+(y0<<6); no multiplier.
- RUN (first write cycle T+2):
  - we_o=1, addr_o=row_base+x, wdata_o=colour. All outputs registered.
  - x steps x0..x_end-1. At row end: x=x0, row_base+=FB_W, y+=1. After the last pixel of row y_end-1 -> DONE.
  - stall_i=1: that cycle we_o=0 and the position does not advance. The same pixel is issued when stall_i falls. No skips, no duplicates.
  - N clipped pixels with no stall: writes occupy cycles T+2..T+N+1.
- DONE:
  - done_o=1 for exactly one cycle, at T+N+2 (T+2 if empty). we_o=0.
  - Next cycle IDLE: cmd_ready_o=1.
- cmd_ready_o=0 outside IDLE; cmd_valid_i is ignored then, so back-to-back commands are separated by at least the SETUP and DONE cycles.
- Width rules: address max 76799 fits AW=17. x0+w and y0+h are computed with one extra bit, so they never wrap.

Decomposition:
- Shared package fb_pkg:
  - FB_W, FB_H, AW, DW constants, also used by the VGA read side.
  - RGB444 pixel typedef.
  - State enum {IDLE, SETUP, RUN, DONE}.
- One natural sub-module: fb_rect_clip, a purely combinational block that produces x_end, y_end, empty and row_base0 from latched command fields.

Test Plan:
- Reset: assert rst=0 mid-idle and mid-RUN -> we_o, busy_o, done_o = 0 immediately. After release: cmd_ready_o=1, no writes.
- Rect x0=10, y0=5, w=3, h=2, colour 0xF00, accepted at T -> we_o on T+2..T+7 with addr 1610, 1611, 1612, 1930, 1931, 1932, wdata 0xF00; done_o at T+8 only; cmd_ready_o=1 at T+9.
- Clip x0=318, y0=239, w=5, h=4 -> exactly two writes, addr 76798 then 76799; done_o at T+4.
- Empty: w=0 (and separately x0=320) -> no we_o; done_o at T+2.
- Stall: rect x0=0, y0=0, w=4, h=1; stall_i=1 for 3 cycles after the 2nd write -> we_o=0 in those cycles; addr sequence exactly 0, 1, 2, 3; done_o at T+9.
- Full clear x0=0, y0=0, w=320, h=240, colour 0x000 -> 76800 writes, each address 0..76799 exactly once in order; cmd_valid_i held high throughout is not re-accepted until after done_o at T+76802.
